// File: rtl/aes_key_expander_if.sv
// Key-schedule bus between the AES key expander and its consumers (round pipeline / control).
// The master starts expansions and selects a slot; the expander returns the slot contents and status.
interface aes_key_expander_if;
    logic         start;
    logic [127:0] cipherKey;
    logic [3:0]   rdRound;
    logic [127:0] rdKey;
    logic         busy;
    logic         keysReady;

    modport master (
        output start, cipherKey, rdRound,
        input  rdKey, busy, keysReady
    );

    modport slave (
        input  start, cipherKey, rdRound,
        output rdKey, busy, keysReady
    );
endinterface

// File: rtl/aes_key_expander.sv
// Iterative AES-128 key schedule: one round key per clock into a NUM_ROUNDS+1 slot store,
// read combinationally by slot index. Slots become readable as soon as they are written.
//
//  state    | meaning
//  ---------+--------------------------------------------------------------
//  S_IDLE   | no valid key set; waiting for start
//  S_EXPAND | writing slot r_count from slot r_count-1 each cycle
//  S_READY  | all slots valid; start restarts expansion
module aes_key_expander #(
    parameter int NUM_ROUNDS = 10
) (
    input  logic               clock,
    input  logic               reset_n,
    aes_key_expander_if.slave  kx
);

    localparam logic [1:0] S_IDLE   = 2'd0;
    localparam logic [1:0] S_EXPAND = 2'd1;
    localparam logic [1:0] S_READY  = 2'd2;
    localparam logic [3:0] LAST     = 4'(NUM_ROUNDS);

    // Forward S-box, byte 0x00 in the most significant byte.
    localparam logic [2047:0] SBOX = {
        128'h637c777bf26b6fc53001672bfed7ab76,
        128'hca82c97dfa5947f0add4a2af9ca472c0,
        128'hb7fd9326363ff7cc34a5e5f171d83115,
        128'h04c723c31896059a071280e2eb27b275,
        128'h09832c1a1b6e5aa0523bd6b329e32f84,
        128'h53d100ed20fcb15b6acbbe394a4c58cf,
        128'hd0efaafb434d338545f9027f503c9fa8,
        128'h51a3408f929d38f5bcb6da2110fff3d2,
        128'hcd0c13ec5f974417c4a77e3d645d1973,
        128'h60814fdc222a908846eeb814de5e0bdb,
        128'he0323a0a4906245cc2d3ac629195e479,
        128'he7c8376d8dd54ea96c56f4ea657aae08,
        128'hba78252e1ca6b4c6e8dd741f4bbd8b8a,
        128'h703eb5664803f60e613557b986c11d9e,
        128'he1f8981169d98e949b1e87e9ce5528df,
        128'h8ca1890dbfe6426841992d0fb054bb16
    };

    function automatic logic [7:0] f_sbox(input logic [7:0] b);
        logic [10:0] idx;
        idx = {~b, 3'b111};
        return SBOX[idx -: 8];
    endfunction

    logic [1:0]   r_state;
    logic [3:0]   r_count;
    logic [7:0]   r_rcon;
    logic [127:0] r_store [0:NUM_ROUNDS];

    logic [127:0] w_prev;
    logic [127:0] w_next;
    logic [127:0] w_rd;
    logic [31:0]  w_p0, w_p1, w_p2, w_p3;
    logic [31:0]  w_rot, w_sub;
    logic [31:0]  w_w0, w_w1, w_w2, w_w3;
    logic [7:0]   w_rcon_next;

    always_comb begin
        w_prev = '0;
        for (int k = 0; k < NUM_ROUNDS; k++) begin
            if (r_count == 4'(k + 1)) w_prev = r_store[k];
        end
    end

    assign {w_p0, w_p1, w_p2, w_p3} = w_prev;
    assign w_rot = {w_p3[23:0], w_p3[31:24]};
    assign w_sub = {f_sbox(w_rot[31:24]), f_sbox(w_rot[23:16]),
                    f_sbox(w_rot[15:8]),  f_sbox(w_rot[7:0])};
    assign w_w0   = w_p0 ^ w_sub ^ {r_rcon, 24'h0};
    assign w_w1   = w_w0 ^ w_p1;
    assign w_w2   = w_w1 ^ w_p2;
    assign w_w3   = w_w2 ^ w_p3;
    assign w_next = {w_w0, w_w1, w_w2, w_w3};

    assign w_rcon_next = {r_rcon[6:0], 1'b0} ^ (r_rcon[7] ? 8'h1b : 8'h00);

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            r_state <= S_IDLE;
            r_count <= '0;
            r_rcon  <= 8'h01;
            for (int k = 0; k <= NUM_ROUNDS; k++) r_store[k] <= '0;
        end else begin
            case (r_state)
                S_IDLE, S_READY: begin
                    if (kx.start) begin
                        r_store[0] <= kx.cipherKey;
                        r_rcon     <= 8'h01;
                        r_count    <= 4'd1;
                        r_state    <= S_EXPAND;
                    end
                end
                S_EXPAND: begin
                    for (int k = 1; k <= NUM_ROUNDS; k++) begin
                        if (r_count == 4'(k)) r_store[k] <= w_next;
                    end
                    r_rcon <= w_rcon_next;
                    // Count parks on the last slot so it never exceeds NUM_ROUNDS.
                    if (r_count == LAST) r_state <= S_READY;
                    else                 r_count <= r_count + 4'd1;
                end
                default: r_state <= S_IDLE;
            endcase
        end
    end

    always_comb begin
        w_rd = '0;
        for (int k = 0; k <= NUM_ROUNDS; k++) begin
            if (kx.rdRound == 4'(k)) w_rd = r_store[k];
        end
    end

    assign kx.rdKey     = w_rd;
    assign kx.busy      = (r_state == S_EXPAND);
    assign kx.keysReady = (r_state == S_READY);

endmodule
